// File: rtl/ann_mon_pkg.sv
// Shared types and constants for the ANN checkpoint monitor.
// The monitor and its bench both import this package.
package ann_mon_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_PASS = 2'd2,
        ST_FAIL = 2'd3
    } mon_state_e;

    localparam logic [7:0] DEFAULT_TAG = 8'hAB;

    // Stage-index width: has to hold every value from 0 up to n inclusive.
    function automatic int sidx_w(input int n);
        return $clog2(n) + 1;
    endfunction

endpackage

// File: rtl/ann_checkpoint_monitor_filter.sv
// Glitch filter for the checkbits bus. It registers the input once, requires a
// stable run of samples, and pulses change_event when the accepted value moves.
module checkbits_filter #(
    parameter int WIDTH         = 16,
    parameter int STABLE_CYCLES = 2
) (
    input  logic             clock,
    input  logic             resetb,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] filt_value,
    output logic             change_event
);

    localparam int CW = $clog2(STABLE_CYCLES + 1);
    localparam logic [CW-1:0] STABLE_MAX = CW'(STABLE_CYCLES);

    logic [WIDTH-1:0] sample_q, sample_d;
    logic [WIDTH-1:0] filt_q, filt_d;
    logic [CW-1:0]    stab_cnt_q, stab_cnt_d;
    logic             event_q, event_d;

    // stab_cnt counts how many consecutive cycles sample_q has held its current value.
    always_comb begin
        sample_d = din;
        filt_d   = filt_q;
        event_d  = 1'b0;
        if (din != sample_q) begin
            stab_cnt_d = CW'(1);
        end else if (stab_cnt_q != STABLE_MAX) begin
            stab_cnt_d = stab_cnt_q + CW'(1);
        end else begin
            stab_cnt_d = stab_cnt_q;
        end
        if (stab_cnt_q == STABLE_MAX) begin
            filt_d  = sample_q;
            event_d = (sample_q != filt_q);
        end
    end

    always_ff @(posedge clock) begin
        if (!resetb) begin
            sample_q   <= '0;
            filt_q     <= '0;
            stab_cnt_q <= '0;
            event_q    <= 1'b0;
        end else begin
            sample_q   <= sample_d;
            filt_q     <= filt_d;
            stab_cnt_q <= stab_cnt_d;
            event_q    <= event_d;
        end
    end

    assign filt_value   = filt_q;
    assign change_event = event_q;

endmodule

// File: rtl/ann_checkpoint_monitor.sv
// Checks that an ordered list of tagged checkpoint words appears on the
// checkbits bus, and reports pass or fail (timeout or wrong checkpoint).
module ann_checkpoint_monitor
    import ann_mon_pkg::*;
#(
    parameter int WIDTH         = 16,
    parameter int NUM_STAGES    = 4,
    parameter int CNT_W         = 20,
    parameter int STABLE_CYCLES = 2,
    parameter int TAG_W         = 8,
    parameter logic [TAG_W-1:0] TAG = TAG_W'(DEFAULT_TAG),
    localparam int SIDX_W       = sidx_w(NUM_STAGES)
) (
    input  logic                        clock,
    input  logic                        resetb,
    input  logic                        start,
    input  logic                        abort,
    input  logic                        strict,
    input  logic [SIDX_W-1:0]           num_stages,
    input  logic [NUM_STAGES*WIDTH-1:0] exp_sig,
    input  logic [CNT_W-1:0]            timeout_limit,
    input  logic [WIDTH-1:0]            checkbits,
    output logic                        busy,
    output logic [SIDX_W-1:0]           stage,
    output logic                        stage_hit,
    output logic                        pass,
    output logic                        fail,
    output logic                        timed_out,
    output logic [WIDTH-1:0]            err_value,
    output logic [CNT_W-1:0]            cycle_count
);

    logic [WIDTH-1:0] filt_value;
    logic             change_event;

    checkbits_filter #(
        .WIDTH        (WIDTH),
        .STABLE_CYCLES(STABLE_CYCLES)
    ) u_filter (
        .clock       (clock),
        .resetb      (resetb),
        .din         (checkbits),
        .filt_value  (filt_value),
        .change_event(change_event)
    );

    mon_state_e        state_q, state_d;
    logic [SIDX_W-1:0] stage_q, stage_d;
    logic              stage_hit_q, stage_hit_d;
    logic              pass_q, pass_d;
    logic              fail_q, fail_d;
    logic              timed_out_q, timed_out_d;
    logic [WIDTH-1:0]  err_value_q, err_value_d;
    logic [CNT_W-1:0]  cycle_count_q, cycle_count_d;
    logic              busy_q, busy_d;

    logic [SIDX_W-1:0] eff_stages;
    logic [SIDX_W-1:0] stage_inc;
    logic [WIDTH-1:0]  cur_sig;
    logic [CNT_W-1:0]  count_inc;
    logic              is_match;
    logic              is_strict_fail;
    logic              is_timeout;

    assign eff_stages = (num_stages > SIDX_W'(NUM_STAGES)) ? SIDX_W'(NUM_STAGES) : num_stages;
    assign stage_inc  = stage_q + SIDX_W'(1);
    assign count_inc  = (cycle_count_q == '1) ? cycle_count_q : cycle_count_q + CNT_W'(1);

    always_comb begin
        cur_sig = '0;
        for (int i = 0; i < NUM_STAGES; i++) begin
            if (stage_q == SIDX_W'(i)) begin
                cur_sig = exp_sig[i*WIDTH +: WIDTH];
            end
        end
    end

    assign is_match       = change_event && (filt_value == cur_sig);
    assign is_strict_fail = change_event && strict && (filt_value[WIDTH-1 -: TAG_W] == TAG);
    // Compared against the incremented count so the run fails after exactly
    // timeout_limit cycles in WAIT, and cycle_count shows that limit on exit.
    assign is_timeout     = (timeout_limit != '0) && (count_inc == timeout_limit);

    always_comb begin
        state_d       = state_q;
        stage_d       = stage_q;
        stage_hit_d   = 1'b0;
        pass_d        = pass_q;
        fail_d        = fail_q;
        timed_out_d   = timed_out_q;
        err_value_d   = err_value_q;
        cycle_count_d = cycle_count_q;
        if (abort) begin
            state_d     = ST_IDLE;
            stage_d     = '0;
            pass_d      = 1'b0;
            fail_d      = 1'b0;
            timed_out_d = 1'b0;
            err_value_d = '0;
        end else begin
            case (state_q)
                ST_WAIT: begin
                    cycle_count_d = count_inc;
                    if (is_match) begin
                        stage_d     = stage_inc;
                        stage_hit_d = 1'b1;
                        if (stage_inc == eff_stages) begin
                            state_d = ST_PASS;
                            pass_d  = 1'b1;
                        end
                    end else if (is_strict_fail) begin
                        state_d     = ST_FAIL;
                        fail_d      = 1'b1;
                        err_value_d = filt_value;
                    end else if (is_timeout) begin
                        state_d     = ST_FAIL;
                        fail_d      = 1'b1;
                        timed_out_d = 1'b1;
                    end
                end
                default: begin
                    if (start) begin
                        stage_d       = '0;
                        pass_d        = 1'b0;
                        fail_d        = 1'b0;
                        timed_out_d   = 1'b0;
                        err_value_d   = '0;
                        cycle_count_d = '0;
                        if (eff_stages == '0) begin
                            state_d = ST_PASS;
                            pass_d  = 1'b1;
                        end else begin
                            state_d = ST_WAIT;
                        end
                    end
                end
            endcase
        end
        busy_d = (state_d == ST_WAIT);
    end

    always_ff @(posedge clock) begin
        if (!resetb) begin
            state_q       <= ST_IDLE;
            stage_q       <= '0;
            stage_hit_q   <= 1'b0;
            pass_q        <= 1'b0;
            fail_q        <= 1'b0;
            timed_out_q   <= 1'b0;
            err_value_q   <= '0;
            cycle_count_q <= '0;
            busy_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            stage_q       <= stage_d;
            stage_hit_q   <= stage_hit_d;
            pass_q        <= pass_d;
            fail_q        <= fail_d;
            timed_out_q   <= timed_out_d;
            err_value_q   <= err_value_d;
            cycle_count_q <= cycle_count_d;
            busy_q        <= busy_d;
        end
    end

    assign busy        = busy_q;
    assign stage       = stage_q;
    assign stage_hit   = stage_hit_q;
    assign pass        = pass_q;
    assign fail        = fail_q;
    assign timed_out   = timed_out_q;
    assign err_value   = err_value_q;
    assign cycle_count = cycle_count_q;

endmodule

// File: tb/tb_ann_checkpoint_monitor.sv
// Bench for ann_checkpoint_monitor: scenario tasks drive checkpoint sequences
// and compare stage, flags and counters against bench-computed expectations.
module tb_ann_checkpoint_monitor;

    localparam int WIDTH      = 16;
    localparam int NUM_STAGES = 4;
    localparam int CNT_W      = 20;
    localparam int STABLE     = 2;
    localparam int SIDX_W     = 3;
    localparam int LAT        = STABLE + 2;

    logic                        clock = 1'b0;
    logic                        resetb;
    logic                        start;
    logic                        abort;
    logic                        strict;
    logic [SIDX_W-1:0]           num_stages;
    logic [NUM_STAGES*WIDTH-1:0] exp_sig;
    logic [CNT_W-1:0]            timeout_limit;
    logic [WIDTH-1:0]            checkbits;
    logic                        busy;
    logic [SIDX_W-1:0]           stage;
    logic                        stage_hit;
    logic                        pass;
    logic                        fail;
    logic                        timed_out;
    logic [WIDTH-1:0]            err_value;
    logic [CNT_W-1:0]            cycle_count;

    logic [SIDX_W-1:0] exp_q[$];
    int n_checks  = 0;
    int n_errors  = 0;
    int cyc       = 0;
    int start_cyc = 0;

    ann_checkpoint_monitor dut (
        .clock        (clock),
        .resetb       (resetb),
        .start        (start),
        .abort        (abort),
        .strict       (strict),
        .num_stages   (num_stages),
        .exp_sig      (exp_sig),
        .timeout_limit(timeout_limit),
        .checkbits    (checkbits),
        .busy         (busy),
        .stage        (stage),
        .stage_hit    (stage_hit),
        .pass         (pass),
        .fail         (fail),
        .timed_out    (timed_out),
        .err_value    (err_value),
        .cycle_count  (cycle_count)
    );

    always #5 clock = ~clock;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clock);
            #1;
            cyc++;
        end
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
        start_cyc = cyc;
    endtask

    task automatic pulse_abort();
        abort = 1'b1;
        tick();
        abort = 1'b0;
    endtask

    task automatic set_sigs(input logic [15:0] s0, input logic [15:0] s1,
                            input logic [15:0] s2, input logic [15:0] s3);
        exp_sig = {s3, s2, s1, s0};
    endtask

    // Drives a value and returns the number of edges until stage_hit, or -1.
    task automatic drive_wait_hit(input logic [15:0] v, input int budget, output int lat);
        checkbits = v;
        lat = -1;
        for (int i = 1; i <= budget; i++) begin
            tick();
            if (stage_hit === 1'b1) begin
                lat = i;
                break;
            end
        end
    endtask

    task automatic test_reset();
        resetb = 1'b0; start = 1'b0; abort = 1'b0; strict = 1'b0;
        num_stages = '0; exp_sig = '0; timeout_limit = '0; checkbits = '0;
        tick(3);
        n_checks++; if ({busy, stage, stage_hit, pass, fail, timed_out} !== '0) begin n_errors++;
            $display("FAIL reset_flags: got %b expected 0", {busy, stage, stage_hit, pass, fail, timed_out}); end
        n_checks++; if (err_value !== '0) begin n_errors++;
            $display("FAIL reset_err_value: got %h expected 0", err_value); end
        n_checks++; if (cycle_count !== '0) begin n_errors++;
            $display("FAIL reset_cycle_count: got %0d expected 0", cycle_count); end
        resetb = 1'b1;
        tick(4);
    endtask

    task automatic test_basic_pass();
        int lat;
        logic [SIDX_W-1:0] e;
        num_stages = 3'd2; set_sigs(16'hAB60, 16'hAB61, 16'h0, 16'h0);
        timeout_limit = 20'd70000; checkbits = 16'h0000;
        tick(4);
        pulse_start();
        n_checks++; if (busy !== 1'b1 || stage !== 3'd0) begin n_errors++;
            $display("FAIL basic_enter_wait: got busy=%b stage=%0d expected busy=1 stage=0", busy, stage); end
        exp_q.push_back(3'd1);
        drive_wait_hit(16'hAB60, 10, lat);
        e = exp_q.pop_front();
        n_checks++; if (lat != LAT) begin n_errors++;
            $display("FAIL basic_latency1: got %0d expected %0d", lat, LAT); end
        n_checks++; if (stage !== e) begin n_errors++;
            $display("FAIL basic_stage1: got %0d expected %0d", stage, e); end
        tick(10 - LAT);
        n_checks++; if (stage_hit !== 1'b0 || pass !== 1'b0) begin n_errors++;
            $display("FAIL basic_hit_pulse: got hit=%b pass=%b expected 0 0", stage_hit, pass); end
        exp_q.push_back(3'd2);
        drive_wait_hit(16'hAB61, 10, lat);
        e = exp_q.pop_front();
        n_checks++; if (lat != LAT) begin n_errors++;
            $display("FAIL basic_latency2: got %0d expected %0d", lat, LAT); end
        n_checks++; if (stage !== e) begin n_errors++;
            $display("FAIL basic_stage2: got %0d expected %0d", stage, e); end
        n_checks++; if ({pass, fail, busy} !== 3'b100) begin n_errors++;
            $display("FAIL basic_pass_flags: got pass,fail,busy=%b expected 100", {pass, fail, busy}); end
        n_checks++; if (cycle_count !== CNT_W'(cyc - start_cyc)) begin n_errors++;
            $display("FAIL basic_cycle_count: got %0d expected %0d", cycle_count, cyc - start_cyc); end
        tick();
        n_checks++; if (stage_hit !== 1'b0 || pass !== 1'b1 || stage !== 3'd2) begin n_errors++;
            $display("FAIL basic_pass_hold: got hit=%b pass=%b stage=%0d expected 0 1 2", stage_hit, pass, stage); end
    endtask

    task automatic test_glitch();
        int hits = 0;
        pulse_start();
        n_checks++; if ({pass, busy, stage} !== {1'b0, 1'b1, 3'd0} || cycle_count !== '0) begin n_errors++;
            $display("FAIL restart_from_pass: got pass=%b busy=%b stage=%0d cc=%0d expected 0 1 0 0",
                     pass, busy, stage, cycle_count); end
        checkbits = 16'hAB60;
        tick();
        checkbits = 16'h0000;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (stage_hit === 1'b1) hits++;
        end
        n_checks++; if (hits != 0 || stage !== 3'd0 || busy !== 1'b1) begin n_errors++;
            $display("FAIL glitch_reject: got hits=%0d stage=%0d busy=%b expected 0 0 1", hits, stage, busy); end
        pulse_abort();
    endtask

    task automatic test_timeout();
        int lat_f = -1;
        int lat;
        logic [SIDX_W-1:0] e;
        num_stages = 3'd2; timeout_limit = 20'd100; checkbits = 16'h0000;
        tick(4);
        pulse_start();
        for (int i = 1; i <= 200; i++) begin
            tick();
            if (fail === 1'b1) begin
                lat_f = i;
                break;
            end
        end
        n_checks++; if (lat_f != 100) begin n_errors++;
            $display("FAIL timeout_latency: got %0d expected 100", lat_f); end
        n_checks++; if (timed_out !== 1'b1 || pass !== 1'b0 || busy !== 1'b0) begin n_errors++;
            $display("FAIL timeout_flags: got to=%b pass=%b busy=%b expected 1 0 0", timed_out, pass, busy); end
        n_checks++; if (cycle_count !== 20'd100) begin n_errors++;
            $display("FAIL timeout_cycle_count: got %0d expected 100", cycle_count); end
        // A final-stage match landing on the timeout edge must win.
        pulse_abort();
        num_stages = 3'd1; set_sigs(16'hAB60, 16'h0, 16'h0, 16'h0);
        pulse_start();
        tick(100 - LAT);
        exp_q.push_back(3'd1);
        drive_wait_hit(16'hAB60, 10, lat);
        e = exp_q.pop_front();
        n_checks++; if (lat != LAT || stage !== e) begin n_errors++;
            $display("FAIL race_hit: got lat=%0d stage=%0d expected %0d %0d", lat, stage, LAT, e); end
        n_checks++; if ({pass, fail, timed_out} !== 3'b100 || cycle_count !== 20'd100) begin n_errors++;
            $display("FAIL race_flags: got pfto=%b cc=%0d expected 100 100", {pass, fail, timed_out}, cycle_count); end
        pulse_abort();
    endtask

    task automatic test_strict();
        int lat;
        logic [SIDX_W-1:0] e;
        strict = 1'b1; num_stages = 3'd3; timeout_limit = '0;
        set_sigs(16'hAB60, 16'hAB61, 16'hAB63, 16'h0);
        checkbits = 16'h0000;
        tick(4);
        pulse_start();
        exp_q.push_back(3'd1);
        drive_wait_hit(16'hAB60, 10, lat);
        e = exp_q.pop_front();
        n_checks++; if (stage !== e) begin n_errors++;
            $display("FAIL strict_stage1: got %0d expected %0d", stage, e); end
        drive_wait_hit(16'hAB62, LAT, lat);
        n_checks++; if (fail !== 1'b1 || timed_out !== 1'b0 || busy !== 1'b0) begin n_errors++;
            $display("FAIL strict_fail_flags: got fail=%b to=%b busy=%b expected 1 0 0", fail, timed_out, busy); end
        n_checks++; if (err_value !== 16'hAB62 || stage !== 3'd1) begin n_errors++;
            $display("FAIL strict_err_value: got %h stage=%0d expected ab62 1", err_value, stage); end
        pulse_abort();
        strict = 1'b0; checkbits = 16'h0000;
        tick(4);
        pulse_start();
        exp_q.push_back(3'd1);
        drive_wait_hit(16'hAB60, 10, lat);
        e = exp_q.pop_front();
        n_checks++; if (stage !== e) begin n_errors++;
            $display("FAIL lax_stage1: got %0d expected %0d", stage, e); end
        drive_wait_hit(16'hAB62, 6, lat);
        n_checks++; if (busy !== 1'b1 || fail !== 1'b0 || stage !== 3'd1 || lat != -1) begin n_errors++;
            $display("FAIL lax_ignore: got busy=%b fail=%b stage=%0d lat=%0d expected 1 0 1 -1", busy, fail, stage, lat); end
        pulse_abort();
    endtask

    task automatic test_control();
        int lat;
        int exp_cc;
        logic [SIDX_W-1:0] e;
        num_stages = 3'd2; set_sigs(16'hAB60, 16'hAB61, 16'h0, 16'h0);
        checkbits = 16'hAB60;
        tick(5);
        pulse_start();
        drive_wait_hit(16'hAB60, 8, lat);
        n_checks++; if (lat != -1 || stage !== 3'd0) begin n_errors++;
            $display("FAIL preset_no_match: got lat=%0d stage=%0d expected -1 0", lat, stage); end
        drive_wait_hit(16'h0000, 6, lat);
        exp_q.push_back(3'd1);
        drive_wait_hit(16'hAB60, 10, lat);
        e = exp_q.pop_front();
        n_checks++; if (lat != LAT || stage !== e) begin n_errors++;
            $display("FAIL preset_then_change: got lat=%0d stage=%0d expected %0d %0d", lat, stage, LAT, e); end
        tick(2);
        exp_cc = cyc - start_cyc;
        abort = 1'b1; start = 1'b1;
        tick();
        abort = 1'b0; start = 1'b0;
        n_checks++; if ({busy, pass, fail, stage} !== '0) begin n_errors++;
            $display("FAIL abort_start: got busy=%b pass=%b fail=%b stage=%0d expected all 0", busy, pass, fail, stage); end
        n_checks++; if (cycle_count !== CNT_W'(exp_cc)) begin n_errors++;
            $display("FAIL abort_hold_count: got %0d expected %0d", cycle_count, exp_cc); end
        pulse_start();
        drive_wait_hit(16'h0000, 6, lat);
        exp_q.push_back(3'd1);
        drive_wait_hit(16'hAB60, 10, lat);
        e = exp_q.pop_front();
        n_checks++; if (stage !== e) begin n_errors++;
            $display("FAIL reset_setup_stage: got %0d expected %0d", stage, e); end
        resetb = 1'b0;
        tick();
        resetb = 1'b1;
        n_checks++; if ({busy, stage, stage_hit, pass, fail, timed_out, err_value, cycle_count} !== '0) begin n_errors++;
            $display("FAIL midrun_reset: got busy=%b stage=%0d cc=%0d expected all 0", busy, stage, cycle_count); end
        tick(4);
    endtask

    task automatic test_num_stages();
        int lat;
        logic [SIDX_W-1:0] e;
        logic [15:0] sigs [4];
        sigs = '{16'hAB60, 16'hAB61, 16'hAB62, 16'hAB63};
        num_stages = 3'd0; checkbits = 16'h0000;
        tick(4);
        pulse_start();
        n_checks++; if ({pass, busy, stage} !== {1'b1, 1'b0, 3'd0}) begin n_errors++;
            $display("FAIL zero_stages: got pass=%b busy=%b stage=%0d expected 1 0 0", pass, busy, stage); end
        num_stages = 3'd7; set_sigs(sigs[0], sigs[1], sigs[2], sigs[3]);
        pulse_start();
        n_checks++; if (busy !== 1'b1 || pass !== 1'b0) begin n_errors++;
            $display("FAIL clamp_restart: got busy=%b pass=%b expected 1 0", busy, pass); end
        for (int k = 0; k < 4; k++) begin
            exp_q.push_back(SIDX_W'(k + 1));
            drive_wait_hit(sigs[k], 10, lat);
            e = exp_q.pop_front();
            n_checks++; if (stage !== e || lat != LAT) begin n_errors++;
                $display("FAIL clamp_stage: got stage=%0d lat=%0d expected %0d %0d", stage, lat, e, LAT); end
        end
        n_checks++; if (pass !== 1'b1 || busy !== 1'b0 || stage !== 3'd4) begin n_errors++;
            $display("FAIL clamp_pass: got pass=%b busy=%b stage=%0d expected 1 0 4", pass, busy, stage); end
    endtask

    initial begin
        test_reset();
        test_basic_pass();
        test_glitch();
        test_timeout();
        test_strict();
        test_control();
        test_num_stages();
        n_checks++; if (exp_q.size() != 0) begin n_errors++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", exp_q.size()); end
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
